mc_ctrl_fsm: RTL and testbench

//  Parametrised multicycle RV32I control unit for the existing datapath. Sequences IF/ID/EX/MEM/WB.

---
 rtl/mc_pkg.sv | 46 ++++
 rtl/mc_decode.sv | 96 +++++++++
 rtl/mc_ctrl_fsm.sv | 110 +++++++++++
 tb/tb_mc_ctrl_fsm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle RV32I control unit: state codes, opcodes,
// ALU operation encodings and the branch-condition helper.
package mc_pkg;

    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_TRAP = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_LAND = 4'b0000;
    localparam logic [3:0] ALU_LOR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_LESS = 4'b0111;
    localparam logic [3:0] ALU_LSHR = 4'b1000;
    localparam logic [3:0] ALU_LSHL = 4'b1001;
    localparam logic [3:0] ALU_ASHR = 4'b1010;
    localparam logic [3:0] ALU_LXOR = 4'b1101;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } instr_class_e;

    // Branch outcome from the SUB-compare flags; unsupported funct3 never reaches WB.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero, input logic lt);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: ALU operation, operand select, writeback
// select, instruction class and illegal-encoding detection.
module mc_decode
    import mc_pkg::*;
#(
    parameter int ALUW = 4
) (
    input  logic [31:0]     instr_i,
    output logic [ALUW-1:0] alu_ctrl_o,
    output logic            alu_src_o,
    output logic            mem_to_reg_o,
    output instr_class_e    cls_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op;
    logic       f7_std;
    logic       f7_alt;
    logic [3:0] alu;
    logic       unused_instr_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign is_op  = (opcode == OPC_OP);
    assign f7_std = (funct7 == 7'b0000000);
    assign f7_alt = (funct7 == 7'b0100000);
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        alu          = ALU_ADD;
        alu_src_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        cls_o        = CLS_ALU;
        illegal_o    = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                cls_o        = CLS_LOAD;
                alu_src_o    = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            OPC_STORE: begin
                cls_o     = CLS_STORE;
                alu_src_o = 1'b1;
            end
            OPC_BRANCH: begin
                cls_o     = CLS_BRANCH;
                alu       = ALU_SUB;
                illegal_o = !((funct3 == 3'b000) || (funct3 == 3'b001) ||
                              (funct3 == 3'b100) || (funct3 == 3'b101));
            end
            OPC_OPIMM, OPC_OP: begin
                // For OP-IMM the funct7 field is immediate bits, checked only for shifts.
                alu_src_o = !is_op;
                case (funct3)
                    3'b000: begin
                        alu       = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
                        illegal_o = is_op && !f7_std && !f7_alt;
                    end
                    3'b001: begin
                        alu       = ALU_LSHL;
                        illegal_o = !f7_std;
                    end
                    3'b010: begin
                        alu       = ALU_LESS;
                        illegal_o = is_op && !f7_std;
                    end
                    3'b011: illegal_o = 1'b1;
                    3'b100: begin
                        alu       = ALU_LXOR;
                        illegal_o = is_op && !f7_std;
                    end
                    3'b101: begin
                        alu       = f7_alt ? ALU_ASHR : ALU_LSHR;
                        illegal_o = !f7_std && !f7_alt;
                    end
                    3'b110: begin
                        alu       = ALU_LOR;
                        illegal_o = is_op && !f7_std;
                    end
                    default: begin
                        alu       = ALU_LAND;
                        illegal_o = is_op && !f7_std;
                    end
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign alu_ctrl_o = ALUW'(alu);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM (IF/ID/EX/MEM/WB/TRAP) with ready-handshake wait
// counting. Define MC_PERF_CNT_EN to add the cycle_cnt/instret_cnt counters.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ALUW     = 4,
    parameter int WAIT_MAX = 15,
    parameter int SKIP_MEM = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            zero,
    input  logic            lt,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            MemToReg,
    output logic            ALUSrc,
    output logic [ALUW-1:0] ALUCtrl,
    output logic            PCSrc,
    output logic            loadPC,
    output logic            trap,
    output logic [2:0]      state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret_cnt
`endif
);

    localparam logic [7:0] WaitLim = 8'(WAIT_MAX);

    logic [2:0]   state_q, state_d;
    logic [7:0]   wait_q, wait_d;
    instr_class_e cls;
    logic         illegal;
    logic         is_mem;

    mc_decode #(.ALUW(ALUW)) u_decode (
        .instr_i      (instr),
        .alu_ctrl_o   (ALUCtrl),
        .alu_src_o    (ALUSrc),
        .mem_to_reg_o (MemToReg),
        .cls_o        (cls),
        .illegal_o    (illegal)
    );

    assign is_mem = (cls == CLS_LOAD) || (cls == CLS_STORE);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IF:   state_d = imem_ready ? S_ID : ((wait_q == WaitLim) ? S_TRAP : S_IF);
            S_ID:   state_d = illegal ? S_TRAP : S_EX;
            S_EX:   state_d = (is_mem || (SKIP_MEM == 0)) ? S_MEM : S_WB;
            S_MEM: begin
                if (!is_mem || dmem_ready) state_d = S_WB;
                else if (wait_q == WaitLim) state_d = S_TRAP;
            end
            S_WB:   state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
        // Staying put in IF/MEM only happens while waiting on ready.
        if (state_d != state_q) wait_d = '0;
        else if ((state_q == S_IF) || (state_q == S_MEM)) wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign IRWrite  = (state_q == S_IF) && imem_ready;
    assign MemRead  = (state_q == S_MEM) && (cls == CLS_LOAD);
    assign MemWrite = (state_q == S_MEM) && (cls == CLS_STORE);
    assign RegWrite = (state_q == S_WB) && ((cls == CLS_ALU) || (cls == CLS_LOAD));
    assign PCSrc    = (state_q == S_WB) && (cls == CLS_BRANCH) && branch_taken(instr[14:12], zero, lt);
    assign loadPC   = (state_q == S_WB);
    assign trap     = (state_q == S_TRAP);
    assign state_o  = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + 32'd1;
            if (state_q == S_WB) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed cases plus randomized instruction streams
// checked cycle by cycle against a per-instruction trace model.
module tb_mc_ctrl_fsm;

  localparam int W    = 16;
  localparam int WMAX = 4;

  localparam logic [2:0] ST_IF = 3'd1, ST_ID = 3'd2, ST_EX = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd7;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111, A_SRL = 4'b1000, A_SLL = 4'b1001, A_SRA = 4'b1010;
  localparam logic [3:0] A_XOR = 4'b1101;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] instr = '0;
  logic zero = 1'b0, lt = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic IRWrite, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, PCSrc, loadPC, trap;
  logic [3:0] ALUCtrl;
  logic [2:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  mc_ctrl_fsm #(.ALUW(4), .WAIT_MAX(WMAX), .SKIP_MEM(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .lt         (lt),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemToReg   (MemToReg),
    .ALUSrc     (ALUSrc),
    .ALUCtrl    (ALUCtrl),
    .PCSrc      (PCSrc),
    .loadPC     (loadPC),
    .trap       (trap),
    .state_o    (state_o)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  logic [W-1:0] obs;
  assign obs = {state_o, IRWrite, MemRead, MemWrite, RegWrite, PCSrc, loadPC, trap,
                MemToReg, ALUSrc, ALUCtrl};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [1:0]   rdy_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // reference model
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [6:0] strb, input logic [5:0] dec);
    return {st, strb, dec};
  endfunction

  // cls: 0 alu, 1 load, 2 store, 3 branch
  task automatic ref_decode(input logic [31:0] ins, output bit legal, output int cls,
                            output logic [3:0] alu, output bit asrc, output bit m2r);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit is_op, std7, alt7;
    opc = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    is_op = (opc == 7'h33);
    std7 = (f7 == 7'h00);
    alt7 = (f7 == 7'h20);
    legal = 1; cls = 0; alu = A_ADD; asrc = 0; m2r = 0;
    if (opc == 7'h03) begin
      cls = 1; asrc = 1; m2r = 1;
    end else if (opc == 7'h23) begin
      cls = 2; asrc = 1;
    end else if (opc == 7'h63) begin
      cls = 3; alu = A_SUB;
      legal = (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 5);
    end else if (opc == 7'h13 || is_op) begin
      asrc = !is_op;
      case (f3)
        3'd0: begin alu = (is_op && alt7) ? A_SUB : A_ADD; legal = !is_op || std7 || alt7; end
        3'd1: begin alu = A_SLL; legal = std7; end
        3'd2: begin alu = A_SLT; legal = !is_op || std7; end
        3'd3: legal = 0;
        3'd4: begin alu = A_XOR; legal = !is_op || std7; end
        3'd5: begin alu = alt7 ? A_SRA : A_SRL; legal = std7 || alt7; end
        3'd6: begin alu = A_OR; legal = !is_op || std7; end
        default: begin alu = A_AND; legal = !is_op || std7; end
      endcase
    end else begin
      legal = 0;
    end
  endtask

  task automatic push(input logic [W-1:0] e, input logic [W-1:0] m, input logic ir, input logic dr);
    exp_q.push_back(e);
    msk_q.push_back(m);
    rdy_q.push_back({ir, dr});
  endtask

  task automatic push_trap(input logic [W-1:0] m, input logic [5:0] dec);
    for (int k = 0; k < 3; k++) push(mk(ST_TRAP, 7'b0000001, dec), m, rnd(), rnd());
  endtask

  // Builds the whole expected trace of one instruction: iw/dw are the wait cycles
  // before imem_ready/dmem_ready rise; a wait beyond WMAX means the fault path.
  task automatic plan(input logic [31:0] ins, input int iw, input int dw,
                      input logic z, input logic l, output bit trapped);
    bit legal, asrc, m2r, taken, rw;
    int cls;
    logic [3:0] alu;
    logic [5:0] dec;
    logic [W-1:0] m;
    ref_decode(ins, legal, cls, alu, asrc, m2r);
    instr = ins; zero = z; lt = l;
    dec = {m2r, asrc, alu};
    m = legal ? {W{1'b1}} : {{(W-6){1'b1}}, 6'b0};
    trapped = 1;
    for (int k = 0; k <= WMAX && k <= iw; k++)
      push(mk(ST_IF, {(k == iw), 6'b0}, dec), m, (k == iw), rnd());
    if (iw > WMAX) begin push_trap(m, dec); return; end
    push(mk(ST_ID, 7'b0, dec), m, rnd(), rnd());
    if (!legal) begin push_trap(m, dec); return; end
    push(mk(ST_EX, 7'b0, dec), m, rnd(), rnd());
    if (cls == 1 || cls == 2) begin
      for (int k = 0; k <= WMAX && k <= dw; k++)
        push(mk(ST_MEM, {1'b0, (cls == 1), (cls == 2), 4'b0}, dec), m, rnd(), (k == dw));
      if (dw > WMAX) begin push_trap(m, dec); return; end
    end
    case (ins[14:12])
      3'd0: taken = z;
      3'd1: taken = !z;
      3'd4: taken = l;
      default: taken = !l;
    endcase
    taken = taken && (cls == 3);
    rw = (cls == 0) || (cls == 1);
    push(mk(ST_WB, {3'b000, rw, taken, 1'b1, 1'b0}, dec), m, rnd(), rnd());
    trapped = 0;
  endtask

  // driver tasks (entered and left at a falling edge)
  task automatic run(input string tag);
    logic [W-1:0] e, m;
    while (exp_q.size() > 0) begin
      {imem_ready, dmem_ready} = rdy_q.pop_front();
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      #1;
      check_eq(tag, 32'(obs & m), 32'(e & m));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq(tag, 32'(obs[W-1:6]), 32'({ST_IF, 7'b0}));
`ifdef MC_PERF_CNT_EN
    check_eq({tag, "_cyc"}, cycle_cnt, 32'd0);
    check_eq({tag, "_ret"}, instret_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [31:0] ins, input int iw, input int dw,
                      input logic z, input logic l);
    bit tr;
    plan(ins, iw, dw, z, l, tr);
    run(tag);
    if (tr) do_reset({tag, "_rst"});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] f7;
    int k;
    w = $urandom();
    k = $urandom_range(0, 5);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom());
    endcase
    case (k)
      0: begin w[6:0] = 7'h33; w[31:25] = f7; end
      1: begin w[6:0] = 7'h13; w[31:25] = f7; end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
      3: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
      4: w[6:0] = 7'h63;
      default: ;
    endcase
    return w;
  endfunction

  function automatic int rand_wait();
    if ($urandom_range(0, 9) < 7) return $urandom_range(0, 2);
    return $urandom_range(WMAX - 1, WMAX + 1);
  endfunction

  initial begin
    bit tr;
    @(negedge clk);
    do_reset("reset");

    exec("add", 32'h002081B3, 0, 0, 1'b0, 1'b0);
    exec("lw_wait3", 32'h0000A183, 0, 3, 1'b0, 1'b0);
    exec("bne_taken", 32'h00209463, 0, 0, 1'b0, 1'b0);
    exec("bne_not", 32'h00209463, 0, 0, 1'b1, 1'b0);
    exec("blt", 32'h0020C463, 1, 0, 1'b0, 1'b1);
    exec("bge", 32'h0020D463, 0, 0, 1'b0, 1'b1);
    exec("sw_timeout", 32'h0020A023, 0, 1000, 1'b0, 1'b0);
    exec("opc_7f", 32'h0000007F, 0, 0, 1'b0, 1'b0);
    exec("sw_rdy_at_max", 32'h0020A023, 0, WMAX, 1'b0, 1'b0);
    exec("if_rdy_at_max", 32'h002081B3, WMAX, 0, 1'b0, 1'b0);
    exec("if_timeout", 32'h002081B3, WMAX + 1, 0, 1'b0, 1'b0);
    exec("sub", 32'h402081B3, 0, 0, 1'b0, 1'b0);
    exec("bad_f7", 32'h122081B3, 0, 0, 1'b0, 1'b0);

    // reset in the middle of a stalled store
    plan(32'h0020A023, 0, 1000, 1'b0, 1'b0, tr);
    while (exp_q.size() > 5) begin
      void'(exp_q.pop_back());
      void'(msk_q.pop_back());
      void'(rdy_q.pop_back());
    end
    run("sw_mid");
    do_reset("sw_mid_rst");

    for (int i = 0; i < 60; i++)
      exec("rand", rand_instr(), rand_wait(), rand_wait(), rnd(), rnd());

`ifdef MC_PERF_CNT_EN
    do_reset("perf_rst");
    for (int i = 0; i < 10; i++) begin
      plan(32'h002081B3, 0, 0, 1'b0, 1'b0, tr);
      run("perf_add");
    end
    check_eq("perf_instret", instret_cnt, 32'd10);
    check_eq("perf_cycle", cycle_cnt, 32'd40);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
